// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and width helpers for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESENT     = 2'b01,
    WAIT_ACCEPT = 2'b10,
    WAIT_DONE   = 2'b11
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index and counter fields must stay at least one bit wide.
  function automatic int min1_clog2(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter bundle seen by the UART TX arbiter
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int GID_W   = min1_clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      snd_busy;
  logic [DATA_W-1:0]         snd_data;
  logic                      snd_ready;
  logic [GID_W-1:0]          grant_id;
  logic                      timeout_err;

  modport master (
    input  req_valid, req_data, snd_busy,
    output req_ack, snd_data, snd_ready, grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_data, snd_busy,
    input  req_ack, snd_data, snd_ready, grant_id, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin picker: first request after the pointer
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  output logic [GID_W-1:0]   o_winner,
  output logic               o_any_valid
);

  logic [NUM_REQ-1:0] w_rot;
  logic [GID_W-1:0]   w_off;

  // Rotate so bit 0 is the requester just after the pointer, then take the lowest set bit.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_req[GID_W'((int'(i_ptr) + 1 + i) % NUM_REQ)];
    end
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = GID_W'(i);
    end
    o_winner    = GID_W'((int'(i_ptr) + 1 + int'(w_off)) % NUM_REQ);
    o_any_valid = |i_req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between NUM_REQ byte producers, one byte per grant
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int ACCEPT_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_arbiter_if.master   bus
);

  localparam int GID_W = min1_clog2(NUM_REQ);
  localparam int CNT_W = min1_clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(ACCEPT_TIMEOUT);
  localparam logic [GID_W-1:0] C_PTR_INIT = GID_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [GID_W-1:0]    r_ptr;
  logic [GID_W-1:0]    r_grant_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_snd_data;
  logic                r_snd_ready;
  logic [NUM_REQ-1:0]  r_req_ack;
  logic                r_timeout_err;

  logic [GID_W-1:0]    w_winner;
  logic                w_any_valid;
  logic [DATA_W-1:0]   w_win_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_picker (
    .i_req       (bus.req_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == GID_W'(k)) w_win_data = bus.req_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= C_PTR_INIT;
      r_grant_id    <= '0;
      r_cnt         <= '0;
      r_snd_data    <= '0;
      r_snd_ready   <= 1'b0;
      r_req_ack     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_valid && !bus.snd_busy) begin
            r_snd_data <= w_win_data;
            r_grant_id <= w_winner;
            r_state    <= PRESENT;
          end
        end
        PRESENT: begin
          r_snd_ready <= 1'b1;
          r_cnt       <= '0;
          r_state     <= WAIT_ACCEPT;
        end
        WAIT_ACCEPT: begin
          if (bus.snd_busy) begin
            r_snd_ready <= 1'b0;
            r_snd_data  <= '0;
            r_req_ack   <= NUM_REQ'(1) << r_grant_id;
            r_ptr       <= r_grant_id;
            r_state     <= WAIT_DONE;
          end else if (r_cnt == C_TIMEOUT) begin
            // Pointer is left alone so the stalled requester is retried first.
            r_snd_ready   <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.snd_busy) r_state <= IDLE;
        end
        default: begin
          r_snd_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack     = r_req_ack;
  assign bus.snd_data    = r_snd_data;
  assign bus.snd_ready   = r_snd_ready;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (NUM_REQ=2, ACCEPT_TIMEOUT=7)
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [DW-1:0] rdat [N];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .ACCEPT_TIMEOUT (7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.req_data = {rdat[1], rdat[0]};

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]  valid;
    logic [DW-1:0] d0;
    logic          busy;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_ack;
    logic          exp_gid;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.snd_busy  = 1'b0;
    rdat[0]       = '0;
    rdat[1]       = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!bus.snd_ready && k < 30) begin
      tick();
      k++;
    end
    chk(nm, bus.snd_ready, 1);
  endtask

  // Spec rule: first valid requester strictly after the last accepted one, modulo N.
  function automatic int rr_next(input int last, input logic [N-1:0] v);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic run_random();
    int quota;
    int sent [N];
    int gap [N];
    logic [N-1:0] d1h, d2h;
    int last, acc_k, cur_k, delay, blen, cyc, w;
    bit presenting;
    logic prev_rdy, rdy;
    quota = 40;
    do_reset();
    for (int k = 0; k < N; k++) begin
      sent[k] = 0;
      gap[k]  = $urandom_range(0, 3);
    end
    last = N - 1; acc_k = -1; cur_k = -1; delay = 0; blen = 0; cyc = 0;
    presenting = 0; prev_rdy = 0; d1h = '0; d2h = '0;
    while ((sent[0] < quota || sent[1] < quota) && cyc < 20000) begin
      rdy = bus.snd_ready;
      if (acc_k >= 0) begin
        chk("rnd_ack", bus.req_ack, 32'(1) << acc_k);
        chk("rnd_ack_ready_low", rdy, 0);
        sent[acc_k]++;
        last = acc_k;
        bus.req_valid[acc_k] = 1'b0;
        gap[acc_k] = $urandom_range(0, 3);
        acc_k = -1;
      end else begin
        chk("rnd_no_ack", bus.req_ack, 0);
      end
      if (rdy && !prev_rdy) begin
        w = rr_next(last, d2h);
        chk("rnd_grant", bus.grant_id, w);
        cur_k = (w < 0) ? 0 : w;
        chk("rnd_data", bus.snd_data, rdat[cur_k]);
        presenting = 1;
        delay = $urandom_range(0, 5);
      end else if (presenting && !rdy) begin
        chk("rnd_ready_held", rdy, 1);
        presenting = 0;
      end
      if (bus.snd_busy) begin
        blen--;
        if (blen <= 0) bus.snd_busy = 1'b0;
      end else if (presenting) begin
        if (delay == 0) begin
          chk("rnd_accept_data", bus.snd_data, rdat[cur_k]);
          bus.snd_busy = 1'b1;
          blen = $urandom_range(1, 4);
          acc_k = cur_k;
          presenting = 0;
        end else begin
          delay--;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!bus.req_valid[k] && sent[k] < quota) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            rdat[k] = DW'($urandom);
            bus.req_valid[k] = 1'b1;
          end
        end
      end
      d2h = d1h;
      d1h = bus.req_valid;
      prev_rdy = rdy;
      tick();
      cyc++;
    end
    chk("rnd_sent0", sent[0], quota);
    chk("rnd_sent1", sent[1], quota);
    chk("rnd_no_timeout", bus.timeout_err, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit flag;
    int n, acks;

    do_reset();
    chk("rst_ready", bus.snd_ready, 0);
    chk("rst_data", bus.snd_data, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_gid", bus.grant_id, 0);
    chk("rst_terr", bus.timeout_err, 0);

    // Single request: byte presented two cycles after valid, busy three cycles after ready.
    tbl[0] = '{2'b01, 8'h81, 1'b0, 1'b0, 8'h81, 2'b00, 1'b0};
    tbl[1] = '{2'b01, 8'h81, 1'b0, 1'b1, 8'h81, 2'b00, 1'b0};
    tbl[2] = '{2'b01, 8'h81, 1'b0, 1'b1, 8'h81, 2'b00, 1'b0};
    tbl[3] = '{2'b01, 8'h81, 1'b0, 1'b1, 8'h81, 2'b00, 1'b0};
    tbl[4] = '{2'b01, 8'h81, 1'b0, 1'b1, 8'h81, 2'b00, 1'b0};
    tbl[5] = '{2'b01, 8'h81, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0};
    tbl[6] = '{2'b00, 8'h81, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[7] = '{2'b00, 8'h81, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[8] = '{2'b00, 8'h81, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.req_valid = tbl[i].valid;
      rdat[0]       = tbl[i].d0;
      bus.snd_busy  = tbl[i].busy;
      tick();
      chk($sformatf("tbl%0d_ready", i), bus.snd_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_data", i), bus.snd_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_ack", i), bus.req_ack, tbl[i].exp_ack);
      chk($sformatf("tbl%0d_gid", i), bus.grant_id, tbl[i].exp_gid);
      chk($sformatf("tbl%0d_terr", i), bus.timeout_err, 0);
    end

    // Contention: both valid, grants alternate starting with requester 0.
    do_reset();
    rdat[0] = 8'h11; rdat[1] = 8'h22;
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_ready($sformatf("cont%0d_ready", t));
      chk($sformatf("cont%0d_gid", t), bus.grant_id, t % 2);
      chk($sformatf("cont%0d_data", t), bus.snd_data, (t % 2) ? 8'h22 : 8'h11);
      bus.snd_busy = 1'b1;
      tick();
      chk($sformatf("cont%0d_ack", t), bus.req_ack, (t % 2) ? 2'b10 : 2'b01);
      bus.snd_busy = 1'b0;
      tick();
    end
    bus.req_valid = '0;
    tick();

    // Busy gating from reset.
    do_reset();
    bus.snd_busy = 1'b1;
    bus.req_valid = 2'b10;
    rdat[1] = 8'h5A;
    flag = 0;
    repeat (50) begin
      tick();
      if (bus.snd_ready) flag = 1;
    end
    chk("gate_ready_low_while_busy", flag, 0);
    bus.snd_busy = 1'b0;
    tick();
    chk("gate_ready_after_1", bus.snd_ready, 0);
    tick();
    chk("gate_ready_after_2", bus.snd_ready, 1);
    chk("gate_gid", bus.grant_id, 1);
    chk("gate_data", bus.snd_data, 8'h5A);
    bus.snd_busy = 1'b1;
    tick();
    chk("gate_ack", bus.req_ack, 2'b10);
    bus.snd_busy = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();

    // Timeout: requester 0 accepted first, then requester 1 stalls and must be retried first.
    do_reset();
    rdat[0] = 8'h3C;
    bus.req_valid = 2'b01;
    wait_ready("to_pre_ready");
    bus.snd_busy = 1'b1;
    tick();
    chk("to_pre_ack", bus.req_ack, 2'b01);
    bus.snd_busy = 1'b0;
    bus.req_valid = 2'b00;
    repeat (2) tick();
    rdat[1] = 8'hC3;
    bus.req_valid = 2'b10;
    wait_ready("to_ready");
    n = 0; acks = 0;
    while (bus.snd_ready && n < 20) begin
      n++;
      if (n == 3) bus.req_valid = 2'b11;
      tick();
      if (bus.req_ack != 0) acks++;
    end
    chk("to_ready_cycles", n, 8);
    chk("to_terr", bus.timeout_err, 1);
    chk("to_no_ack", acks, 0);
    wait_ready("to_retry_ready");
    chk("to_retry_gid", bus.grant_id, 1);
    chk("to_retry_data", bus.snd_data, 8'hC3);
    chk("to_terr_sticky", bus.timeout_err, 1);

    // Asynchronous reset in WAIT_ACCEPT.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", bus.snd_ready, 0);
    chk("arst_data", bus.snd_data, 0);
    chk("arst_ack", bus.req_ack, 0);
    chk("arst_gid", bus.grant_id, 0);
    chk("arst_terr", bus.timeout_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("arst_first_ready");
    chk("arst_first_gid", bus.grant_id, 0);
    chk("arst_first_data", bus.snd_data, 8'h3C);

    // Back-to-back: requester 0 stays valid after its ack, requester 1 must go next.
    bus.snd_busy = 1'b1;
    tick();
    chk("b2b_ack0", bus.req_ack, 2'b01);
    bus.snd_busy = 1'b0;
    wait_ready("b2b_ready");
    chk("b2b_gid", bus.grant_id, 1);
    chk("b2b_data", bus.snd_data, 8'hC3);
    bus.snd_busy = 1'b1;
    tick();
    chk("b2b_ack1", bus.req_ack, 2'b10);
    bus.snd_busy = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();

    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
